axi4_lite_master_write: RTL and testbench

AXI4-Lite master write engine for single-beat writes to an AXI4-Lite write slave. It accepts one request from the core-side memory interface, drives the AW and W channels concurrently, and waits for the B response. It reports completion and the response code back to the requester. It sits directly upstream of the memory-side AXI4-Lite write slave and drives its AW/W/B channels.

---
 rtl/axi4_lite_master_write.sv | 147 ++++++++++++++
 tb/tb_axi4_lite_master_write.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/axi4_lite_master_write.sv
// Single-beat AXI4-Lite write master: one request is latched, AW and W are
// issued concurrently, and the B response is reported back to the requester.
module axi4_lite_master_write #(
  parameter int unsigned AXI_ADDR_WIDTH = 64,
  parameter int unsigned AXI_DATA_WIDTH = 32
) (
  input  logic                        clk_i,
  input  logic                        arstn_i,
  input  logic                        start_write_i,
  input  logic [AXI_ADDR_WIDTH-1:0]   addr_i,
  input  logic [AXI_DATA_WIDTH-1:0]   data_i,
  input  logic [AXI_DATA_WIDTH/8-1:0] strb_i,
  output logic                        busy_o,
  output logic                        done_o,
  output logic [1:0]                  resp_o,
  output logic                        error_o,
  output logic                        AW_VALID,
  output logic [AXI_ADDR_WIDTH-1:0]   AW_ADDR,
  output logic [2:0]                  AW_PROT,
  input  logic                        AW_READY,
  output logic                        W_VALID,
  output logic [AXI_DATA_WIDTH-1:0]   W_DATA,
  output logic [AXI_DATA_WIDTH/8-1:0] W_STRB,
  input  logic                        W_READY,
  input  logic                        B_VALID,
  input  logic [1:0]                  B_RESP,
  output logic                        B_READY
);

  typedef enum logic [1:0] {IDLE, SEND, RESP} state_e;

  state_e                      state_q, state_d;
  logic                        aw_valid_q, aw_valid_d;
  logic                        w_valid_q, w_valid_d;
  logic                        b_ready_q, b_ready_d;
  logic                        busy_q, busy_d;
  logic                        done_q, done_d;
  logic                        error_q, error_d;
  logic [1:0]                  resp_q, resp_d;
  logic                        aw_done_q, aw_done_d;
  logic                        w_done_q, w_done_d;
  logic [AXI_ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [AXI_DATA_WIDTH-1:0]   data_q, data_d;
  logic [AXI_DATA_WIDTH/8-1:0] strb_q, strb_d;

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      state_q    <= IDLE;
      aw_valid_q <= 1'b0;
      w_valid_q  <= 1'b0;
      b_ready_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
      resp_q     <= '0;
      aw_done_q  <= 1'b0;
      w_done_q   <= 1'b0;
      addr_q     <= '0;
      data_q     <= '0;
      strb_q     <= '0;
    end else begin
      state_q    <= state_d;
      aw_valid_q <= aw_valid_d;
      w_valid_q  <= w_valid_d;
      b_ready_q  <= b_ready_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      error_q    <= error_d;
      resp_q     <= resp_d;
      aw_done_q  <= aw_done_d;
      w_done_q   <= w_done_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      strb_q     <= strb_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    aw_valid_d = aw_valid_q;
    w_valid_d  = w_valid_q;
    b_ready_d  = b_ready_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    error_d    = error_q;
    resp_d     = resp_q;
    aw_done_d  = aw_done_q;
    w_done_d   = w_done_q;
    addr_d     = addr_q;
    data_d     = data_q;
    strb_d     = strb_q;
    unique case (state_q)
      IDLE: begin
        if (start_write_i) begin
          addr_d     = addr_i;
          data_d     = data_i;
          strb_d     = strb_i;
          aw_valid_d = 1'b1;
          w_valid_d  = 1'b1;
          busy_d     = 1'b1;
          aw_done_d  = 1'b0;
          w_done_d   = 1'b0;
          state_d    = SEND;
        end
      end
      SEND: begin
        if (aw_valid_q && AW_READY) begin
          aw_valid_d = 1'b0;
          aw_done_d  = 1'b1;
        end
        if (w_valid_q && W_READY) begin
          w_valid_d = 1'b0;
          w_done_d  = 1'b1;
        end
        // Next-state flags already include a handshake happening this cycle.
        if (aw_done_d && w_done_d) begin
          b_ready_d = 1'b1;
          state_d   = RESP;
        end
      end
      RESP: begin
        if (B_VALID && b_ready_q) begin
          resp_d    = B_RESP;
          error_d   = (B_RESP != 2'b00);
          done_d    = 1'b1;
          b_ready_d = 1'b0;
          busy_d    = 1'b0;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy_o   = busy_q;
  assign done_o   = done_q;
  assign resp_o   = resp_q;
  assign error_o  = error_q;
  assign AW_VALID = aw_valid_q;
  assign AW_ADDR  = addr_q;
  assign AW_PROT  = 3'b000;
  assign W_VALID  = w_valid_q;
  assign W_DATA   = data_q;
  assign W_STRB   = strb_q;
  assign B_READY  = b_ready_q;

endmodule

// File: tb/tb_axi4_lite_master_write.sv
// Bench for axi4_lite_master_write: per-transaction timeline model derived
// from handshake delays, checked cycle by cycle against the engine outputs.
module tb_axi4_lite_master_write;

  logic        clk_i = 1'b0;
  logic        arstn_i = 1'b0;
  logic        start_write_i = 1'b0;
  logic [63:0] addr_i = '0;
  logic [31:0] data_i = '0;
  logic [3:0]  strb_i = '0;
  logic        busy_o, done_o, error_o;
  logic [1:0]  resp_o;
  logic        AW_VALID, W_VALID, B_READY;
  logic [63:0] AW_ADDR;
  logic [2:0]  AW_PROT;
  logic [31:0] W_DATA;
  logic [3:0]  W_STRB;
  logic        AW_READY = 1'b0;
  logic        W_READY = 1'b0;
  logic        B_VALID = 1'b0;
  logic [1:0]  B_RESP = '0;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;
  logic [1:0]  prev_resp = 2'b00;

  always #5 clk_i = ~clk_i;

  axi4_lite_master_write #(.AXI_ADDR_WIDTH(64), .AXI_DATA_WIDTH(32)) dut (
    .clk_i(clk_i), .arstn_i(arstn_i), .start_write_i(start_write_i),
    .addr_i(addr_i), .data_i(data_i), .strb_i(strb_i),
    .busy_o(busy_o), .done_o(done_o), .resp_o(resp_o), .error_o(error_o),
    .AW_VALID(AW_VALID), .AW_ADDR(AW_ADDR), .AW_PROT(AW_PROT), .AW_READY(AW_READY),
    .W_VALID(W_VALID), .W_DATA(W_DATA), .W_STRB(W_STRB), .W_READY(W_READY),
    .B_VALID(B_VALID), .B_RESP(B_RESP), .B_READY(B_READY)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  task automatic chk_idle();
    chk("idle_awv", 64'(AW_VALID), 64'(0));
    chk("idle_wv", 64'(W_VALID), 64'(0));
    chk("idle_brdy", 64'(B_READY), 64'(0));
    chk("idle_busy", 64'(busy_o), 64'(0));
    chk("idle_done", 64'(done_o), 64'(0));
    chk("idle_resp", 64'(resp_o), 64'(prev_resp));
    chk("idle_err", 64'(error_o), 64'(prev_resp != 2'b00));
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk_i); #1;
      start_write_i = 1'b0;
      AW_READY = 1'($urandom);
      W_READY  = 1'($urandom);
      B_VALID  = 1'b0;
      @(negedge clk_i);
      chk_idle();
    end
  endtask

  // Called with the current cycle being cycle 0 (start is driven now).
  // Ends after checking the done_o cycle, leaving the bench in that cycle.
  task automatic run_txn(input logic [63:0] a, input logic [31:0] d, input logic [3:0] s,
                         input int aw_w, input int w_w, input int bv_d,
                         input logic [1:0] r, input bit junk);
    int aw_hs, w_hs, brdy, bv, bhs, dn;
    aw_hs = 1 + aw_w;
    w_hs  = 1 + w_w;
    brdy  = ((aw_hs > w_hs) ? aw_hs : w_hs) + 1;
    bv    = 1 + bv_d;
    bhs   = (bv > brdy) ? bv : brdy;
    dn    = bhs + 1;
    start_write_i = 1'b1;
    addr_i = a;
    data_i = d;
    strb_i = s;
    for (int c = 1; c <= dn; c++) begin
      @(posedge clk_i); #1;
      start_write_i = (c == dn) ? 1'b0 : (junk ? 1'($urandom) : 1'b0);
      addr_i   = 64'h2000;
      data_i   = $urandom;
      strb_i   = 4'($urandom);
      AW_READY = (c >= aw_hs);
      W_READY  = (c >= w_hs);
      B_VALID  = (c >= bv) && (c <= bhs);
      B_RESP   = B_VALID ? r : 2'($urandom);
      @(negedge clk_i);
      chk("aw_valid", 64'(AW_VALID), 64'(c <= aw_hs));
      chk("w_valid", 64'(W_VALID), 64'(c <= w_hs));
      chk("b_ready", 64'(B_READY), 64'((c >= brdy) && (c <= bhs)));
      chk("busy", 64'(busy_o), 64'(c <= bhs));
      chk("done", 64'(done_o), 64'(c == dn));
      chk("aw_prot", 64'(AW_PROT), 64'(0));
      if (c <= aw_hs) chk("aw_addr", AW_ADDR, a);
      if (c <= w_hs) begin
        chk("w_data", 64'(W_DATA), 64'(d));
        chk("w_strb", 64'(W_STRB), 64'(s));
      end
      chk("resp", 64'(resp_o), 64'((c == dn) ? r : prev_resp));
      chk("error", 64'(error_o), 64'((c == dn) ? (r != 2'b00) : (prev_resp != 2'b00)));
    end
    prev_resp = r;
  endtask

  task automatic chk_all_zero();
    chk("rst_awv", 64'(AW_VALID), 64'(0));
    chk("rst_wv", 64'(W_VALID), 64'(0));
    chk("rst_brdy", 64'(B_READY), 64'(0));
    chk("rst_busy", 64'(busy_o), 64'(0));
    chk("rst_done", 64'(done_o), 64'(0));
    chk("rst_err", 64'(error_o), 64'(0));
    chk("rst_resp", 64'(resp_o), 64'(0));
    chk("rst_addr", AW_ADDR, 64'(0));
    chk("rst_data", 64'(W_DATA), 64'(0));
    chk("rst_strb", 64'(W_STRB), 64'(0));
  endtask

  initial begin
    #2;
    chk_all_zero();
    #10 arstn_i = 1'b1;
    idle_cycles(2);

    // Directed: basic, skewed AW, delayed error response, back-to-back pair.
    run_txn(64'h1000, 32'hDEADBEEF, 4'hF, 0, 0, 1, 2'b00, 1'b0);
    idle_cycles(1);
    run_txn(64'h1000, 32'h12345678, 4'h3, 3, 0, 0, 2'b00, 1'b1);
    idle_cycles(1);
    run_txn(64'h1004, 32'hCAFEF00D, 4'hC, 0, 0, 3, 2'b10, 1'b1);
    idle_cycles(2);
    run_txn(64'h1008, 32'h0BADF00D, 4'h1, 1, 2, 0, 2'b01, 1'b0);
    run_txn(64'h3000, 32'hA5A5A5A5, 4'hF, 0, 4, 2, 2'b00, 1'b0);
    idle_cycles(1);

    // Reset while AW/W are stalled.
    @(posedge clk_i); #1;
    start_write_i = 1'b1; addr_i = 64'h4000; data_i = 32'h11112222; strb_i = 4'hF;
    AW_READY = 1'b0; W_READY = 1'b0; B_VALID = 1'b0;
    @(posedge clk_i); #1;
    start_write_i = 1'b0;
    @(negedge clk_i);
    chk("pre_rst_awv", 64'(AW_VALID), 64'(1));
    @(posedge clk_i); #1;
    arstn_i = 1'b0;
    #1;
    chk_all_zero();
    prev_resp = 2'b00;
    @(posedge clk_i);
    @(negedge clk_i);
    arstn_i = 1'b1;
    idle_cycles(1);
    run_txn(64'h5000, 32'h5555AAAA, 4'h6, 0, 1, 0, 2'b00, 1'b1);

    // Randomized transactions, some issued in the done_o cycle.
    for (int t = 0; t < 150; t++) begin
      if ($urandom_range(0, 2) != 0) idle_cycles(int'($urandom_range(1, 2)));
      run_txn({$urandom, $urandom}, $urandom, 4'($urandom),
              int'($urandom_range(0, 4)), int'($urandom_range(0, 4)),
              int'($urandom_range(0, 7)), 2'($urandom), 1'b1);
    end
    idle_cycles(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
